dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Data-memory access controller, directly downstream of the EXU load-store unit. Accepts one registered
//  load/store command per non-bubble cycle and drives a valid/ready data-memory port with byte enables.
//  Returns sign/zero-extended, lane-aligned load data to the writeback path.
//  Stalls the pipeline while a transaction is outstanding. Flags misaligned accesses instead of issuing them.
// PARAMETERS
//  XLEN         32  data/address width; only 32 supported (4 byte lanes)
//  ALIGN_CHECK  1   1: trap misaligned HWORD/WORD; 0: issue word-aligned access, ignore addr[1:0] offset errors
// PORTS
//  clk              in   1     clock
//  aresetn          in   1     asynchronous reset, active-low
//  i_mem_cmd        in   1     0 = load, 1 = store
//  i_mem_addr       in   XLEN  byte address
//  i_mem_size       in   2     BYTE=00 / HWORD=01 / WORD=10 (11 treated as WORD)
//  i_mem_unsigned   in   1     load zero-extend (funct3[2]), registered alongside the command
//  i_mem_data       in   XLEN  store data, already shifted to its byte lane
//  i_bubble         in   1     1 = no command this cycle
//  o_stall          out  1     1 = upstream must hold its outputs
//  o_dmem_req       out  1     request valid
//  i_dmem_ready     in   1     request accepted when req && ready
//  o_dmem_we        out  1     1 = write
//  o_dmem_addr      out  XLEN  word address {addr[XLEN-1:2],2'b00}
//  o_dmem_be        out  4     byte enables
//  o_dmem_wdata     out  XLEN  write data
//  i_dmem_rvalid    in   1     read data valid, one pulse per accepted load
//  i_dmem_rdata     in   XLEN  read word
//  o_ld_valid       out  1     one-cycle pulse: o_ld_data valid
//  o_ld_data        out  XLEN  aligned, extended load result
//  o_misalign_err   out  1     one-cycle pulse: misaligned access dropped
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (o_stall=0, o_dmem_req=0, o_dmem_be=4'h0); captured command cleared.
//  - FSM IDLE/REQ/RESP.
//    - IDLE: if !i_bubble, capture cmd/addr/size/unsigned/data.
//      - Misaligned (ALIGN_CHECK=1: HWORD && addr[0], or WORD && addr[1:0]!=0): pulse o_misalign_err
//        next cycle and stay IDLE.
//      - Otherwise go to REQ.
//    - REQ: o_dmem_req=1. Fields stay stable until ready.
//      - On req && ready: store -> IDLE; load -> RESP.
//    - RESP: wait for i_dmem_rvalid, then register o_ld_data, pulse o_ld_valid, go to IDLE.
//  - o_stall = (state != IDLE), registered. Upstream inputs presented while stalled are not sampled.
//    On return to IDLE, the held inputs are captured as the next command.
//  - Byte enables:
//    - BYTE: 4'b0001 << addr[1:0]
//    - HWORD: 4'b0011 << addr[1:0]
//    - WORD/11: 4'b1111
//  - o_dmem_wdata = captured data, unmodified. o_dmem_we = captured cmd.
//  - Load extraction:
//    - sh = rdata >> (8*addr[1:0]).
//    - BYTE: extend sh[7:0]; HWORD: extend sh[15:0]; WORD: rdata as-is.
//    - Extension is zero if unsigned, else sign.
//  - Latency:
//    - Command capture at edge T; req asserted T..T+k (k = ready wait).
//    - Store is done on acceptance.
//    - For a load, rvalid comes earliest one cycle after acceptance, and o_ld_valid is high the cycle after rvalid.
//    - Min load-to-o_ld_valid latency is 3 cycles; stall cycles = 1 + ready wait + rvalid wait.
//  - Boundaries:
//    - rvalid in IDLE/REQ is ignored (no o_ld_valid).
//    - rvalid and ready are never expected in the same cycle for one load; rvalid in REQ is ignored.
//    - Bubble in IDLE: no state change.
//    - Reset mid-transaction: request dropped immediately, any late rvalid ignored.
//    - addr wrap at 2^XLEN: no special handling.
//  - o_ld_data holds its last value between pulses. o_misalign_err and o_ld_valid are never high together.
// STRUCTURE
//  - pqr5_core_pkg: existing BYTE/HWORD/WORD size constants; add typedef enum logic[1:0] {DM_IDLE,DM_REQ,DM_RESP},
//    function dmem_be(size,addr_lsb), function is_misaligned(size,addr_lsb).
//  - Sub-module load_align_ext (combinational): rdata, addr[1:0], size, unsigned -> extended XLEN word.
//  - Top holds the FSM, capture registers, and output registers.
// TESTING
//  - Store byte: addr 0x1003, data 0xAB000000, ready=1 -> req 1 cycle, be=4'b1000, addr=0x1000, wdata=0xAB000000, stall 1 cycle.
//  - Load signed byte: addr 0x2001, rdata 0x0000_8000 -> o_ld_data 0xFFFF_FF80; unsigned -> 0x0000_0080; o_ld_valid 3 cycles after capture.
//  - Load HWORD: addr 0x2002, rdata 0x7FFE_1234 -> 0x0000_7FFE; ready delayed 3 cycles -> req/addr/be=4'b1100 held stable, stall held throughout.
//  - Misaligned WORD: addr 0x3001 -> o_misalign_err 1-cycle pulse, o_dmem_req never asserted, o_stall stays 0; ALIGN_CHECK=0 -> be=4'hF at 0x3000.
//  - Back-to-back: load then store presented while stalled -> second command captured on return to IDLE, issued in order, no command lost or duplicated.
//  - Reset during RESP, then rvalid pulse -> all outputs 0, no o_ld_valid, next command executes normally.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: access sizes,
// FSM encoding and the byte-enable / alignment helpers.
package dmem_access_ctrl_pkg;

    localparam logic [1:0] BYTE  = 2'b00;
    localparam logic [1:0] HWORD = 2'b01;
    localparam logic [1:0] WORD  = 2'b10;

    typedef enum logic [1:0] {
        DM_IDLE = 2'b00,
        DM_REQ  = 2'b01,
        DM_RESP = 2'b10
    } dm_state_e;

    function automatic logic [3:0] dmem_be(input logic [1:0] size, input logic [1:0] addr_lsb);
        logic [3:0] be_s;
        case (size)
            BYTE:    be_s = 4'b0001 << addr_lsb;
            HWORD:   be_s = 4'b0011 << addr_lsb;
            default: be_s = 4'b1111;
        endcase
        return be_s;
    endfunction

    // Size code 2'b11 is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
        logic mis_s;
        case (size)
            BYTE:    mis_s = 1'b0;
            HWORD:   mis_s = addr_lsb[0];
            default: mis_s = (addr_lsb != 2'b00);
        endcase
        return mis_s;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory port: valid/ready request channel plus a read-data return pulse.
interface dmem_access_ctrl_if #(
    parameter int XLEN = 32
);
    logic            o_dmem_req;
    logic            i_dmem_ready;
    logic            o_dmem_we;
    logic [XLEN-1:0] o_dmem_addr;
    logic [3:0]      o_dmem_be;
    logic [XLEN-1:0] o_dmem_wdata;
    logic            i_dmem_rvalid;
    logic [XLEN-1:0] i_dmem_rdata;

    modport master (
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        input  i_dmem_ready, i_dmem_rvalid, i_dmem_rdata
    );

    modport slave (
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        output i_dmem_ready, i_dmem_rvalid, i_dmem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl_load_align_ext.sv
// Combinational load formatter: picks the addressed byte/halfword out of the
// returned word and sign- or zero-extends it.
module dmem_access_ctrl_load_align_ext
    import dmem_access_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lsb,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        fill_b_s;
    logic        fill_h_s;

    // Lane selection equivalent to rdata >> (8*addr_lsb).
    always_comb begin
        case (addr_lsb)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        case (addr_lsb)
            2'd0:    half_s = rdata[15:0];
            2'd1:    half_s = rdata[23:8];
            2'd2:    half_s = rdata[31:16];
            default: half_s = {8'h00, rdata[31:24]};
        endcase
    end

    assign fill_b_s = ~is_unsigned & byte_s[7];
    assign fill_h_s = ~is_unsigned & half_s[15];

    // Extension by access size.
    always_comb begin
        case (size)
            BYTE:    data = {{(XLEN-8){fill_b_s}}, byte_s};
            HWORD:   data = {{(XLEN-16){fill_h_s}}, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: captures one load/store command from the LSU,
// runs it on the valid/ready memory port and returns formatted load data.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 i_mem_cmd,
    input  logic [XLEN-1:0]      i_mem_addr,
    input  logic [1:0]           i_mem_size,
    input  logic                 i_mem_unsigned,
    input  logic [XLEN-1:0]      i_mem_data,
    input  logic                 i_bubble,
    output logic                 o_stall,
    dmem_access_ctrl_if.master   dmem,
    output logic                 o_ld_valid,
    output logic [XLEN-1:0]      o_ld_data,
    output logic                 o_misalign_err
);

    localparam logic [1:0] ST_IDLE = DM_IDLE;
    localparam logic [1:0] ST_REQ  = DM_REQ;
    localparam logic [1:0] ST_RESP = DM_RESP;

    logic [1:0]      state_r;
    logic [1:0]      state_nx_s;
    logic            capture_s;
    logic            issue_s;
    logic            misalign_s;
    logic            ld_done_s;

    logic            cmd_r;
    logic [1:0]      size_r;
    logic [1:0]      lsb_r;
    logic            uns_r;

    logic            stall_r;
    logic            req_r;
    logic            we_r;
    logic [XLEN-1:0] addr_r;
    logic [3:0]      be_r;
    logic [XLEN-1:0] wdata_r;
    logic            ld_valid_r;
    logic [XLEN-1:0] ld_data_r;
    logic            mis_r;
    logic [XLEN-1:0] ext_s;

    // Next-state decode; inputs are only looked at while idle.
    always_comb begin
        state_nx_s = state_r;
        capture_s  = 1'b0;
        issue_s    = 1'b0;
        misalign_s = 1'b0;
        ld_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!i_bubble) begin
                    capture_s = 1'b1;
                    if (ALIGN_CHECK && is_misaligned(i_mem_size, i_mem_addr[1:0])) begin
                        misalign_s = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        issue_s    = 1'b1;
                        state_nx_s = ST_REQ;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem.i_dmem_ready) begin
                    state_nx_s = cmd_r ? ST_IDLE : ST_RESP;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (dmem.i_dmem_rvalid) begin
                    ld_done_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register and captured command fields needed after issue.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
            cmd_r   <= 1'b0;
            size_r  <= 2'b00;
            lsb_r   <= 2'b00;
            uns_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (capture_s) begin
                cmd_r  <= i_mem_cmd;
                size_r <= i_mem_size;
                lsb_r  <= i_mem_addr[1:0];
                uns_r  <= i_mem_unsigned;
            end
        end
    end

    // Output registers; request fields load at issue and hold until the next one.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stall_r    <= 1'b0;
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= {XLEN{1'b0}};
            be_r       <= 4'h0;
            wdata_r    <= {XLEN{1'b0}};
            ld_valid_r <= 1'b0;
            ld_data_r  <= {XLEN{1'b0}};
            mis_r      <= 1'b0;
        end else begin
            stall_r    <= (state_nx_s != ST_IDLE);
            req_r      <= (state_nx_s == ST_REQ);
            ld_valid_r <= ld_done_s;
            mis_r      <= misalign_s;
            if (issue_s) begin
                we_r    <= i_mem_cmd;
                addr_r  <= {i_mem_addr[XLEN-1:2], 2'b00};
                be_r    <= dmem_be(i_mem_size, i_mem_addr[1:0]);
                wdata_r <= i_mem_data;
            end
            if (ld_done_s) begin
                ld_data_r <= ext_s;
            end
        end
    end

    dmem_access_ctrl_load_align_ext #(
        .XLEN(XLEN)
    ) u_ld_ext (
        .rdata      (dmem.i_dmem_rdata),
        .addr_lsb   (lsb_r),
        .size       (size_r),
        .is_unsigned(uns_r),
        .data       (ext_s)
    );

    assign o_stall           = stall_r;
    assign dmem.o_dmem_req   = req_r;
    assign dmem.o_dmem_we    = we_r;
    assign dmem.o_dmem_addr  = addr_r;
    assign dmem.o_dmem_be    = be_r;
    assign dmem.o_dmem_wdata = wdata_r;
    assign o_ld_valid        = ld_valid_r;
    assign o_ld_data         = ld_data_r;
    assign o_misalign_err    = mis_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed commands push expected
// memory requests / load results / misalign pulses; a negedge monitor checks them.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    logic        clk;
    logic        aresetn;
    logic        mem_cmd, mem_uns, bubble;
    logic [31:0] mem_addr, mem_data;
    logic [1:0]  mem_size;
    logic        stall, ld_valid, mis;
    logic [31:0] ld_data;

    logic        na_cmd, na_uns, na_bubble;
    logic [31:0] na_addr, na_data;
    logic [1:0]  na_size;
    logic        na_stall, na_ld_valid, na_mis;
    logic [31:0] na_ld_data;

    int n_cmp = 0;
    int n_mis = 0;
    int ready_wait = 0;
    int rv_wait = 0;
    bit inject_rv = 1'b0;

    req_t        exp_req_q[$];
    logic [31:0] exp_ld_q[$];
    bit          exp_mis_q[$];
    logic [31:0] rdata_q[$];

    dmem_access_ctrl_if #(.XLEN(32)) bus ();
    dmem_access_ctrl_if #(.XLEN(32)) bus_na ();

    dmem_access_ctrl #(.XLEN(32), .ALIGN_CHECK(1'b1)) u_dut (
        .clk(clk), .aresetn(aresetn), .i_mem_cmd(mem_cmd), .i_mem_addr(mem_addr),
        .i_mem_size(mem_size), .i_mem_unsigned(mem_uns), .i_mem_data(mem_data),
        .i_bubble(bubble), .o_stall(stall), .dmem(bus), .o_ld_valid(ld_valid),
        .o_ld_data(ld_data), .o_misalign_err(mis)
    );

    dmem_access_ctrl #(.XLEN(32), .ALIGN_CHECK(1'b0)) u_dut_na (
        .clk(clk), .aresetn(aresetn), .i_mem_cmd(na_cmd), .i_mem_addr(na_addr),
        .i_mem_size(na_size), .i_mem_unsigned(na_uns), .i_mem_data(na_data),
        .i_bubble(na_bubble), .o_stall(na_stall), .dmem(bus_na), .o_ld_valid(na_ld_valid),
        .o_ld_data(na_ld_data), .o_misalign_err(na_mis)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: ready after ready_wait cycles of req, rvalid rv_wait cycles after the earliest slot.
    initial begin : mem_model
        int  wcnt, rvcnt;
        bit  pend, prev_req, prev_ready, prev_we, acc;
        wcnt = 0; rvcnt = 0; pend = 1'b0;
        prev_req = 1'b0; prev_ready = 1'b0; prev_we = 1'b0;
        bus.i_dmem_ready  = 1'b0;
        bus.i_dmem_rvalid = 1'b0;
        bus.i_dmem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!aresetn) begin
                bus.i_dmem_ready  = 1'b0;
                bus.i_dmem_rvalid = 1'b0;
                prev_req = 1'b0; prev_ready = 1'b0; wcnt = 0;
                continue;
            end
            acc = prev_req && prev_ready;
            bus.i_dmem_rvalid = 1'b0;
            if (acc && !prev_we) begin
                pend  = 1'b1;
                rvcnt = rv_wait;
            end
            if (pend) begin
                if (rvcnt == 0) begin
                    bus.i_dmem_rvalid = 1'b1;
                    bus.i_dmem_rdata  = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'h0;
                    pend = 1'b0;
                end else begin
                    rvcnt--;
                end
            end
            if (inject_rv) begin
                bus.i_dmem_rvalid = 1'b1;
                bus.i_dmem_rdata  = 32'hDEAD_BEEF;
                inject_rv = 1'b0;
            end
            if (bus.o_dmem_req) begin
                bus.i_dmem_ready = (wcnt >= ready_wait);
                wcnt++;
            end else begin
                bus.i_dmem_ready = 1'b0;
                wcnt = 0;
            end
            prev_req   = bus.o_dmem_req;
            prev_ready = bus.i_dmem_ready;
            prev_we    = bus.o_dmem_we;
        end
    end

    initial begin
        bus_na.i_dmem_ready  = 1'b1;
        bus_na.i_dmem_rvalid = 1'b0;
        bus_na.i_dmem_rdata  = 32'h0;
    end

    // Scoreboard monitor.
    req_t held;
    bit   held_valid = 1'b0;
    always @(negedge clk) begin
        req_t got, e;
        if (aresetn) begin
            got = '{bus.o_dmem_we, bus.o_dmem_addr, bus.o_dmem_be, bus.o_dmem_wdata};
            if (bus.o_dmem_req) begin
                if (held_valid) chk("req_stable", 72'(got), 72'(held));
                if (bus.i_dmem_ready) begin
                    if (exp_req_q.size() == 0) begin
                        chk("req_unexpected", 72'(1), 72'(0));
                    end else begin
                        e = exp_req_q.pop_front();
                        chk("req_we", 72'(got.we), 72'(e.we));
                        chk("req_addr", 72'(got.addr), 72'(e.addr));
                        chk("req_be", 72'(got.be), 72'(e.be));
                        chk("req_wdata", 72'(got.wdata), 72'(e.wdata));
                    end
                    held_valid = 1'b0;
                end else begin
                    held = got;
                    held_valid = 1'b1;
                end
            end else begin
                held_valid = 1'b0;
            end
            if (ld_valid) begin
                if (exp_ld_q.size() == 0) chk("ld_unexpected", 72'(ld_data), 72'(0));
                else chk("ld_data", 72'(ld_data), 72'(exp_ld_q.pop_front()));
            end
            if (mis) begin
                if (exp_mis_q.size() == 0) chk("misalign_unexpected", 72'(1), 72'(0));
                else chk("misalign", 72'(mis), 72'(exp_mis_q.pop_front()));
            end
            if (mis && ld_valid) chk("mis_and_ld_together", 72'(1), 72'(0));
        end else begin
            held_valid = 1'b0;
        end
    end

    // Present a command and hold it until an edge where the DUT was not stalling.
    task automatic issue(input logic cmd, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] data);
        logic st;
        bit   done;
        done = 1'b0;
        @(posedge clk);
        #1;
        mem_cmd = cmd; mem_addr = addr; mem_size = size; mem_uns = uns; mem_data = data;
        bubble = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            st = stall;
            @(posedge clk);
            if (!st) done = 1'b1;
        end
        chk("issue_captured", 72'(done), 72'(1));
        #1;
        bubble = 1'b1;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] data, input logic [3:0] be);
        exp_req_q.push_back('{1'b1, addr & 32'hFFFF_FFFC, be, data});
        issue(1'b1, addr, size, 1'b0, data);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp);
        exp_req_q.push_back('{1'b0, addr & 32'hFFFF_FFFC, be, 32'h0});
        rdata_q.push_back(rd);
        exp_ld_q.push_back(exp);
        issue(1'b0, addr, size, uns, 32'h0);
    endtask

    task automatic do_misaligned(input logic [31:0] addr, input logic [1:0] size);
        exp_mis_q.push_back(1'b1);
        issue(1'b0, addr, size, 1'b0, 32'h0);
    endtask

    // Counts stall cycles and capture-to-o_ld_valid latency after an issue.
    task automatic measure(input string name, input int exp_stall, input int exp_lat, input bit inj);
        int k, sn, lat;
        bit done;
        k = 0; sn = 0; lat = 0; done = 1'b0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
            if (inj && k == 1) inject_rv = 1'b1;
            if (stall) sn++;
            if (ld_valid && lat == 0) lat = k;
            if (!stall && (exp_lat == 0 || lat != 0)) done = 1'b1;
        end
        chk({name, "_done"}, 72'(done), 72'(1));
        chk({name, "_stall"}, 72'(sn), 72'(exp_stall));
        if (exp_lat != 0) chk({name, "_lat"}, 72'(lat), 72'(exp_lat));
    endtask

    initial begin
        mem_cmd = 1'b0; mem_addr = 32'h0; mem_size = 2'b00; mem_uns = 1'b0; mem_data = 32'h0;
        bubble = 1'b1;
        na_cmd = 1'b0; na_addr = 32'h0; na_size = 2'b00; na_uns = 1'b0; na_data = 32'h0;
        na_bubble = 1'b1;
        aresetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stall", 72'(stall), 72'(0));
        chk("rst_req", 72'(bus.o_dmem_req), 72'(0));
        chk("rst_be", 72'(bus.o_dmem_be), 72'(0));
        chk("rst_we", 72'(bus.o_dmem_we), 72'(0));
        chk("rst_addr", 72'(bus.o_dmem_addr), 72'(0));
        chk("rst_ld_valid", 72'(ld_valid), 72'(0));
        chk("rst_ld_data", 72'(ld_data), 72'(0));
        chk("rst_misalign", 72'(mis), 72'(0));
        aresetn = 1'b1;

        // Stores and loads with an immediately ready memory.
        do_store(32'h0000_1003, BYTE, 32'hAB00_0000, 4'b1000);
        measure("st_byte", 1, 0, 1'b0);
        do_store(32'h0000_1002, HWORD, 32'h1234_0000, 4'b1100);
        measure("st_half", 1, 0, 1'b0);
        do_load(32'h0000_2001, BYTE, 1'b0, 32'h0000_8000, 4'b0010, 32'hFFFF_FF80);
        measure("ld_sbyte", 2, 3, 1'b0);
        do_load(32'h0000_2001, BYTE, 1'b1, 32'h0000_8000, 4'b0010, 32'h0000_0080);
        measure("ld_ubyte", 2, 3, 1'b0);
        do_load(32'h0000_2003, BYTE, 1'b0, 32'hF000_0000, 4'b1000, 32'hFFFF_FFF0);
        measure("ld_sbyte3", 2, 3, 1'b0);
        do_load(32'h0000_2000, HWORD, 1'b0, 32'h0000_8001, 4'b0011, 32'hFFFF_8001);
        measure("ld_shalf", 2, 3, 1'b0);
        do_load(32'h0000_2002, HWORD, 1'b1, 32'hBEEF_0000, 4'b1100, 32'h0000_BEEF);
        measure("ld_uhalf", 2, 3, 1'b0);
        do_load(32'h0000_2004, WORD, 1'b0, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF);
        measure("ld_word", 2, 3, 1'b0);
        do_load(32'h0000_2008, 2'b11, 1'b0, 32'h0102_0304, 4'b1111, 32'h0102_0304);
        measure("ld_size11", 2, 3, 1'b0);

        // Ready delayed 3 cycles, stray rvalid while still in REQ.
        ready_wait = 3;
        do_load(32'h0000_2002, HWORD, 1'b0, 32'h7FFE_1234, 4'b1100, 32'h0000_7FFE);
        measure("ld_half_wait", 5, 6, 1'b1);
        ready_wait = 0;

        // Misaligned accesses are dropped with a pulse and no request.
        do_misaligned(32'h0000_3001, WORD);
        measure("mis_word", 0, 0, 1'b0);
        do_misaligned(32'h0000_3003, HWORD);
        measure("mis_half", 0, 0, 1'b0);
        do_misaligned(32'h0000_3002, WORD);
        measure("mis_word2", 0, 0, 1'b0);

        // Back-to-back: store held while the load is outstanding.
        rv_wait = 2;
        do_load(32'h0000_4000, WORD, 1'b0, 32'h1122_3344, 4'b1111, 32'h1122_3344);
        do_store(32'h0000_4004, WORD, 32'h5566_7788, 4'b1111);
        measure("b2b_store", 1, 0, 1'b0);
        rv_wait = 0;

        // Stray rvalid while idle.
        @(negedge clk);
        inject_rv = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_stall", 72'(stall), 72'(0));

        // Reset while waiting in RESP; the late rvalid must be ignored.
        rv_wait = 5;
        exp_req_q.push_back('{1'b0, 32'h0000_5000, 4'b1111, 32'h0});
        rdata_q.push_back(32'hCAFE_F00D);
        issue(1'b0, 32'h0000_5000, WORD, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        chk("resp_stall_before_rst", 72'(stall), 72'(1));
        aresetn = 1'b0;
        #1;
        chk("mrst_stall", 72'(stall), 72'(0));
        chk("mrst_req", 72'(bus.o_dmem_req), 72'(0));
        chk("mrst_be", 72'(bus.o_dmem_be), 72'(0));
        chk("mrst_ld_valid", 72'(ld_valid), 72'(0));
        chk("mrst_ld_data", 72'(ld_data), 72'(0));
        @(negedge clk);
        aresetn = 1'b1;
        repeat (12) @(negedge clk);
        chk("late_rvalid_consumed", 72'(rdata_q.size()), 72'(0));
        rv_wait = 0;
        do_load(32'h0000_2001, BYTE, 1'b1, 32'h0000_8000, 4'b0010, 32'h0000_0080);
        measure("ld_after_rst", 2, 3, 1'b0);

        // Alignment check disabled: misaligned word goes out word-aligned.
        @(posedge clk);
        #1;
        na_cmd = 1'b1; na_addr = 32'h0000_3001; na_size = WORD; na_data = 32'h0BAD_F00D;
        na_bubble = 1'b0;
        @(posedge clk);
        #1;
        na_bubble = 1'b1;
        @(negedge clk);
        chk("na_req", 72'(bus_na.o_dmem_req), 72'(1));
        chk("na_be", 72'(bus_na.o_dmem_be), 72'(4'hF));
        chk("na_addr", 72'(bus_na.o_dmem_addr), 72'(32'h0000_3000));
        chk("na_wdata", 72'(bus_na.o_dmem_wdata), 72'(32'h0BAD_F00D));
        chk("na_misalign", 72'(na_mis), 72'(0));
        @(negedge clk);
        chk("na_req_done", 72'(bus_na.o_dmem_req), 72'(0));
        chk("na_stall_done", 72'(na_stall), 72'(0));

        repeat (5) @(negedge clk);
        chk("exp_req_left", 72'(exp_req_q.size()), 72'(0));
        chk("exp_ld_left", 72'(exp_ld_q.size()), 72'(0));
        chk("exp_mis_left", 72'(exp_mis_q.size()), 72'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
